// File: rtl/cordiv_pkg.sv
// Shared constants and helpers for the stochastic divider array:
// LFSR geometry, feedback taps, default seed and select slicing.
package cordiv_pkg;

  localparam int LFSR_W = 16;

  // Right-shift Fibonacci form of taps 16,14,13,11
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;

  localparam logic [LFSR_W-1:0] LFSR_SEED_DEF = 16'hACE1;

  function automatic logic [LFSR_W-1:0] lfsr_next(
    input logic [LFSR_W-1:0] v
  );
    return {^(v & LFSR_TAPS), v[LFSR_W-1:1]};
  endfunction

  function automatic logic [LFSR_W-1:0] sel_slice(
    input logic [LFSR_W-1:0] v,
    input int                lane,
    input int                w
  );
    logic [LFSR_W-1:0] mask;
    mask = (LFSR_W'(1) << w) - LFSR_W'(1);
    return (v >> (lane * w)) & mask;
  endfunction

endpackage

// File: rtl/cordiv_lane.sv
// One divider lane: history shift register, select mux,
// quotient register, fill tracking and window accumulator.
module cordiv_lane
  import cordiv_pkg::*;
#(
  parameter int SRDEPTH = 2,
  parameter int SELW    = 1,
  parameter int CNTW    = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            en,
  input  logic            wrap,
  input  logic            dividend,
  input  logic            divisor,
  input  logic [SELW-1:0] sel,
  output logic            quotient,
  output logic            qvalid,
  output logic [CNTW:0]   qsum
);

  localparam int FW = $clog2(SRDEPTH + 1);
  localparam int AW = CNTW + 1;

  logic [SRDEPTH-1:0] sr_q, sr_d;
  logic               quo_q, quo_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic [AW-1:0]      acc_q, acc_d;
  logic [AW-1:0]      qsum_q, qsum_d;
  logic               q_new;

  // Divisor low: replay a stored dividend bit instead of shifting
  assign q_new = divisor ? dividend : sr_q[sel];

  always_comb begin
    sr_d   = sr_q;
    quo_d  = quo_q;
    fill_d = fill_q;
    acc_d  = acc_q;
    qsum_d = qsum_q;
    if (clr) begin
      sr_d   = '0;
      quo_d  = 1'b0;
      fill_d = '0;
      acc_d  = '0;
      qsum_d = '0;
    end else if (en) begin
      quo_d = q_new;
      if (divisor) begin
        sr_d = {sr_q[SRDEPTH-2:0], dividend};
        if (fill_q != FW'(SRDEPTH)) begin
          fill_d = fill_q + FW'(1);
        end
      end
      if (wrap) begin
        qsum_d = acc_q + AW'(q_new);
        acc_d  = '0;
      end else begin
        acc_d = acc_q + AW'(q_new);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q   <= '0;
      quo_q  <= 1'b0;
      fill_q <= '0;
      acc_q  <= '0;
      qsum_q <= '0;
    end else begin
      sr_q   <= sr_d;
      quo_q  <= quo_d;
      fill_q <= fill_d;
      acc_q  <= acc_d;
      qsum_q <= qsum_d;
    end
  end

  assign quotient = quo_q;
  assign qvalid   = (fill_q == FW'(SRDEPTH));
  assign qsum     = qsum_q;

endmodule

// File: rtl/cordiv_array.sv
// Array of stochastic divider lanes sharing an LFSR select
// source, a window counter and the window-done pulse.
module cordiv_array
  import cordiv_pkg::*;
#(
  parameter int                NCH          = 4,
  parameter int                SRDEPTH      = 2,
  parameter int                SELW         = $clog2(SRDEPTH),
  parameter int                SEL_INTERNAL = 1,
  parameter logic [LFSR_W-1:0] LFSR_SEED    = LFSR_SEED_DEF,
  parameter int                CNTW         = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   en,
  input  logic [NCH-1:0]         dividend,
  input  logic [NCH-1:0]         divisor,
  input  logic [NCH*SELW-1:0]    sel_ext,
  output logic [NCH-1:0]         quotient,
  output logic [NCH-1:0]         qvalid,
  output logic [NCH*(CNTW+1)-1:0] qsum,
  output logic                   done
);

  if (NCH * SELW > LFSR_W) begin : g_sel_range
    $error("cordiv_array: NCH*SELW exceeds LFSR width");
  end

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [CNTW-1:0]   win_q, win_d;
  logic              done_q, done_d;
  logic              wrap;
  logic              sel_unused;

  assign wrap       = &win_q;
  assign sel_unused = ^sel_ext;

  always_comb begin
    lfsr_d = lfsr_q;
    win_d  = win_q;
    done_d = 1'b0;
    if (clr) begin
      lfsr_d = LFSR_SEED;
      win_d  = '0;
    end else if (en) begin
      lfsr_d = lfsr_next(lfsr_q);
      win_d  = win_q + CNTW'(1);
      done_d = wrap;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
      win_q  <= '0;
      done_q <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      win_q  <= win_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    logic [SELW-1:0] sel;
    if (SEL_INTERNAL != 0) begin : g_int
      assign sel = SELW'(sel_slice(lfsr_q, i, SELW));
    end else begin : g_ext
      assign sel = sel_ext[i*SELW +: SELW];
    end

    cordiv_lane #(
      .SRDEPTH (SRDEPTH),
      .SELW    (SELW),
      .CNTW    (CNTW)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .en       (en),
      .wrap     (wrap),
      .dividend (dividend[i]),
      .divisor  (divisor[i]),
      .sel      (sel),
      .quotient (quotient[i]),
      .qvalid   (qvalid[i]),
      .qsum     (qsum[i*(CNTW+1) +: CNTW+1])
    );
  end

endmodule

// File: doc/cordiv_array.md
CORDIV_ARRAY -- requirements
Module: cordiv_array

Interface
REQ-001 The block SHALL take parameter NCH, default 4: number of independent divider lanes.
REQ-002 The block SHALL take parameter SRDEPTH, default 2: per-lane shift-register depth; power of two, >=2.
REQ-003 The block SHALL take parameter SELW, default clog2(SRDEPTH): width of one lane's select field.
REQ-004 The block SHALL take parameter SEL_INTERNAL, default 1: 1 = selects from the internal LFSR, 0 = from sel_ext.
REQ-005 The block SHALL take parameter LFSR_SEED, default 16'hACE1: LFSR reset/clear value; nonzero.
REQ-006 The block SHALL take parameter CNTW, default 8: window length is 2^CNTW enabled cycles.
REQ-007 The block SHALL have port clk, input, 1: clock, rising edge.
REQ-008 The block SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-009 The block SHALL have port clr, input, 1: synchronous clear.
REQ-010 The block SHALL have port en, input, 1: bit-slot advance.
REQ-011 The block SHALL have port dividend, input, NCH: dividend bit per lane.
REQ-012 The block SHALL have port divisor, input, NCH: divisor bit per lane.
REQ-013 The block SHALL have port sel_ext, input, NCH*SELW: external select, lane i at [i*SELW +: SELW].
REQ-014 The block SHALL have port quotient, output, NCH: registered quotient bit per lane.
REQ-015 The block SHALL have port qvalid, output, NCH: lane shift register fully written since last reset/clear.
REQ-016 The block SHALL have port qsum, output, NCH*(CNTW+1): quotient-ones count of the last completed window per lane.
REQ-017 The block SHALL have port done, output, 1: one-cycle pulse when a window completes.

Function
REQ-018 With en=1 and divisor[i]=1, lane i SHALL register quotient[i]<=dividend[i] and shift SR_i: SR_i[0]<=dividend[i], SR_i[k]<=SR_i[k-1].
REQ-019 With en=1 and divisor[i]=0, lane i SHALL register quotient[i]<=SR_i[sel_i] and leave SR_i unchanged.
REQ-020 Quotient latency SHALL be exactly one clock from the sampled inputs; with en=0, quotient, SR, counters and LFSR SHALL hold.
REQ-021 sel_i SHALL be sel_ext[i*SELW +: SELW] when SEL_INTERNAL=0, else lfsr[i*SELW +: SELW]; NCH*SELW<=16 is required, checked by elaboration assertion.
REQ-022 The LFSR SHALL be 16-bit Fibonacci, taps 16,14,13,11, advancing once per en=1 cycle; selects use its pre-advance value.
REQ-023 Per lane, a fill counter SHALL count divisor=1 shifts, saturating at SRDEPTH; qvalid[i]=1 once the count reaches SRDEPTH.
REQ-024 A window counter (CNTW bits) SHALL increment per en=1 cycle and wrap from 2^CNTW-1 to 0.
REQ-025 Per lane, an accumulator (CNTW+1 bits) SHALL add the new quotient bit each en=1 cycle; it cannot overflow.
REQ-026 On the wrapping en cycle, qsum[i] SHALL load accumulator+new bit, the accumulator SHALL clear to 0, and done SHALL be 1 the following cycle only.
REQ-027 qsum SHALL hold between window completions.
REQ-028 clr=1 SHALL zero SR, quotient, fill, window, accumulator, qsum, done and reload LFSR_SEED; clr SHALL win over a simultaneous en.
REQ-029 Lanes SHALL be fully independent except for the shared en, clr, window counter and LFSR.

Reset
REQ-030 rst_n=0 SHALL asynchronously force: quotient=0, qvalid=0, qsum=0, done=0, SR=0, all counters=0, LFSR=LFSR_SEED.
REQ-031 Reset asserted mid-window SHALL discard partial counts; the first window after deassertion SHALL be a full 2^CNTW en cycles.

Structure
REQ-032 A shared package cordiv_pkg SHALL hold the LFSR width, tap constants, default seed, and the select-slice helper function.
REQ-033 One sub-module cordiv_lane (SR, select mux, quotient register, fill counter, accumulator) SHALL be instantiated NCH times; the LFSR, window counter and done SHALL live in the top level.

Verification
REQ-034 Reset, then drive NCH=4, SEL_INTERNAL=0, SRDEPTH=2, en=1, divisor=1111 with dividend=1010 for 2 cycles: quotient SHALL be 1010 one cycle later, and qvalid SHALL be 1111 after the second shift.
REQ-035 With SR_0={1,0} (SR[0]=0, SR[1]=1), drive divisor[0]=0, sel_ext lane0=1: quotient[0]=1; with sel_ext lane0=0: quotient[0]=0; SR SHALL be unchanged.
REQ-036 With CNTW=4, hold divisor=1 and dividend=1 for 16 en cycles: done SHALL pulse once on cycle 17 and qsum SHALL be 16 on every lane.
REQ-037 Drive a Bernoulli dividend p=0.25 and divisor p=0.5 (dividend generated as divisor AND a p=0.5 stream), CNTW=10, SEL_INTERNAL=1: each lane's qsum/1024 SHALL be 0.5+-0.06.
REQ-038 Assert clr together with en mid-window: the next cycle SHALL show quotient=0, qvalid=0, qsum=0, and the LFSR SHALL equal LFSR_SEED.
REQ-039 Drop rst_n asynchronously between clock edges mid-window: outputs SHALL go to reset values without waiting for a clock edge, and the next done SHALL arrive 2^CNTW en cycles after deassertion.
